// File: rtl/apb3_pwm_pkg.sv
// apb3_pwm_pkg: shared constants for the APB3 PWM LED peripheral.
//   - register byte offsets (CTRL, PRESCALE, PERIOD, STATUS, DUTY_BASE)
//   - CTRL / STATUS bit positions
//   - prescaler width and the APB slave FSM state type
package apb3_pwm_pkg;

    localparam int PRESCALE_W = 16;

    localparam int OFF_CTRL      = 'h00;
    localparam int OFF_PRESCALE  = 'h04;
    localparam int OFF_PERIOD    = 'h08;
    localparam int OFF_STATUS    = 'h0C;
    localparam int OFF_DUTY_BASE = 'h10;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_POL       = 2;
    localparam int CTRL_CH_EN_LSB = 8;

    localparam int STATUS_WRAP_PEND = 0;
    localparam int STATUS_RUNNING   = 1;

    typedef enum logic [1:0] {
        APB_IDLE = 2'd0,
        APB_WAIT = 2'd1,
        APB_RESP = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb3_pwm_led_if.sv
// apb3_pwm_led_if: APB3 bus bundle between SoC master and the PWM peripheral.
//   PADDR, PSEL, PENABLE, PWRITE, PWDATA : master -> slave
//   PREADY, PRDATA, PSLVERROR            : slave -> master
interface apb3_pwm_led_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERROR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERROR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERROR
    );
endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler + period counter for the PWM channels.
//   clk, rst   : clock, synchronous active-high reset
//   en         : run enable; when low both counters are held at 0
//   prescale   : tick every prescale+1 clocks
//   period_act : cnt runs 0..period_act, one step per tick
//   cnt        : current period count
//   wrap       : single-cycle pulse on the tick where cnt returns to 0
module pwm_timebase
    import apb3_pwm_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [CNT_WIDTH-1:0]  period_act,
    output logic [CNT_WIDTH-1:0]  cnt,
    output logic                  wrap
);

    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  tick;

    // >= rather than == so a prescale lowered below pre_cnt still ticks
    assign tick = pre_cnt >= prescale;
    assign wrap = en && tick && (cnt >= period_act);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pre_cnt <= '0;
            cnt     <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            cnt     <= (cnt >= period_act) ? '0 : cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb3_pwm_led.sv
// apb3_pwm_led: APB3 slave with NUM_CH PWM LED outputs and a wrap interrupt.
//   io_systemClk, io_systemReset : clock, synchronous active-high reset
//   apb                          : APB3 slave bus (one wait state per transfer)
//   apb3LED                      : registered PWM outputs
//   apb3Interrupt                : registered level interrupt (WRAP_PEND & IRQ_EN)
module apb3_pwm_led
    import apb3_pwm_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              io_systemClk,
    input  logic              io_systemReset,
    apb3_pwm_led_if.slave     apb,
    output logic [NUM_CH-1:0] apb3LED,
    output logic              apb3Interrupt
);

    localparam int WW = ADDR_WIDTH - 2;
    localparam logic [WW-1:0] W_CTRL     = WW'(OFF_CTRL / 4);
    localparam logic [WW-1:0] W_PRESCALE = WW'(OFF_PRESCALE / 4);
    localparam logic [WW-1:0] W_PERIOD   = WW'(OFF_PERIOD / 4);
    localparam logic [WW-1:0] W_STATUS   = WW'(OFF_STATUS / 4);

    apb_state_e            state;
    logic                  pready_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pslverr_q;

    logic                  en, irq_en, pol;
    logic [NUM_CH-1:0]     ch_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [CNT_WIDTH-1:0]  period_sh, period_act;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] duty_sh, duty_act;
    logic                  wrap_pend, irq_q;
    logic [NUM_CH-1:0]     led_q;

    logic [CNT_WIDTH-1:0]  cnt;
    logic                  wrap;

    logic [WW-1:0]         word;
    logic                  sel_ctrl, sel_pre, sel_per, sel_stat, addr_ok, wr_commit;
    logic [NUM_CH-1:0]     duty_sel;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_bits;

    assign apb.PREADY    = pready_q;
    assign apb.PRDATA    = prdata_q;
    assign apb.PSLVERROR = pslverr_q;
    assign apb3LED       = led_q;
    assign apb3Interrupt = irq_q;

    // byte lane bits are ignored; upper PWDATA bits have no home
    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

    // ---------------- address decode ----------------
    assign word     = apb.PADDR[ADDR_WIDTH-1:2];
    assign sel_ctrl = (word == W_CTRL);
    assign sel_pre  = (word == W_PRESCALE);
    assign sel_per  = (word == W_PERIOD);
    assign sel_stat = (word == W_STATUS);

    always_comb begin
        duty_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            duty_sel[i] = (word == WW'(OFF_DUTY_BASE / 4 + i));
    end

    assign addr_ok = sel_ctrl | sel_pre | sel_per | sel_stat | (|duty_sel);

    // Selects are mutually exclusive, so the ORed fills never collide.
    always_comb begin
        rd_val = '0;
        if (sel_ctrl) begin
            rd_val[CTRL_EN]                     = en;
            rd_val[CTRL_IRQ_EN]                 = irq_en;
            rd_val[CTRL_POL]                    = pol;
            rd_val[CTRL_CH_EN_LSB +: NUM_CH]    = ch_en;
        end
        if (sel_pre) rd_val[PRESCALE_W-1:0] = prescale;
        if (sel_per) rd_val[CNT_WIDTH-1:0]  = period_sh;
        if (sel_stat) begin
            rd_val[STATUS_WRAP_PEND] = wrap_pend;
            rd_val[STATUS_RUNNING]   = en;
        end
        for (int i = 0; i < NUM_CH; i++)
            if (duty_sel[i]) rd_val[CNT_WIDTH-1:0] = duty_sh[i];
    end

    // ---------------- APB slave FSM ----------------
    // IDLE sees the setup phase, WAIT is the first access cycle (PREADY=0),
    // RESP is the PREADY=1 cycle; writes commit on the edge that leaves RESP.
    // A reset drops back to IDLE, so a transfer cut by reset never commits.
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            state     <= APB_IDLE;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            case (state)
                APB_IDLE: if (apb.PSEL && !apb.PENABLE) state <= APB_WAIT;
                APB_WAIT: begin
                    if (!apb.PSEL) begin
                        state <= APB_IDLE;
                    end else if (apb.PENABLE) begin
                        state     <= APB_RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= !addr_ok;
                        prdata_q  <= (!apb.PWRITE && addr_ok) ? rd_val : '0;
                    end
                end
                APB_RESP: state <= APB_IDLE;
                default:  state <= APB_IDLE;
            endcase
        end
    end

    assign wr_commit = (state == APB_RESP) && apb.PSEL && apb.PENABLE && apb.PWRITE;

    // ---------------- timebase ----------------
    pwm_timebase #(.CNT_WIDTH(CNT_WIDTH)) u_timebase (
        .clk        (io_systemClk),
        .rst        (io_systemReset),
        .en         (en),
        .prescale   (prescale),
        .period_act (period_act),
        .cnt        (cnt),
        .wrap       (wrap)
    );

    // ---------------- registers, shadows, outputs ----------------
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            en         <= 1'b0;
            irq_en     <= 1'b0;
            pol        <= 1'b0;
            ch_en      <= '0;
            prescale   <= '0;
            period_sh  <= '0;
            period_act <= '0;
            duty_sh    <= '0;
            duty_act   <= '0;
            wrap_pend  <= 1'b0;
            irq_q      <= 1'b0;
            led_q      <= '0;
        end else begin
            if (wr_commit && sel_ctrl) begin
                en     <= apb.PWDATA[CTRL_EN];
                irq_en <= apb.PWDATA[CTRL_IRQ_EN];
                pol    <= apb.PWDATA[CTRL_POL];
                ch_en  <= apb.PWDATA[CTRL_CH_EN_LSB +: NUM_CH];
            end
            if (wr_commit && sel_pre) prescale  <= apb.PWDATA[PRESCALE_W-1:0];
            if (wr_commit && sel_per) period_sh <= apb.PWDATA[CNT_WIDTH-1:0];
            for (int i = 0; i < NUM_CH; i++)
                if (wr_commit && duty_sel[i]) duty_sh[i] <= apb.PWDATA[CNT_WIDTH-1:0];

            // Track shadows continuously while stopped so the first period
            // after enable already uses the latest values.
            if (!en || wrap) begin
                period_act <= period_sh;
                duty_act   <= duty_sh;
            end

            // set beats a simultaneous W1C so no wrap is ever lost
            if (wrap)
                wrap_pend <= 1'b1;
            else if (wr_commit && sel_stat && apb.PWDATA[STATUS_WRAP_PEND])
                wrap_pend <= 1'b0;

            irq_q <= wrap_pend & irq_en;

            for (int i = 0; i < NUM_CH; i++)
                led_q[i] <= (en & ch_en[i] & (cnt < duty_act[i])) ^ pol;
        end
    end

endmodule

// File: tb/tb_apb3_pwm_led.sv
// tb_apb3_pwm_led: directed self-checking bench for apb3_pwm_led.
module tb_apb3_pwm_led;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] led;
    logic       irq;

    int n_cmp = 0;
    int n_err = 0;

    apb3_pwm_led_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    apb3_pwm_led #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_CH(2), .CNT_WIDTH(16)
    ) dut (
        .io_systemClk   (clk),
        .io_systemReset (rst),
        .apb            (bus),
        .apb3LED        (led),
        .apb3Interrupt  (irq)
    );

    always #5 clk = ~clk;

    // run-length / edge monitor, sampled on the falling edge
    int   cyc = 0;
    int   run0 = 0;
    logic prev0 = 1'b0;
    logic prev_irq = 1'b0;
    int   hiq[$];
    int   loq[$];
    int   irq_rise[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (led[0] !== prev0) begin
            if (prev0) hiq.push_back(run0);
            else       loq.push_back(run0);
            run0 <= 1;
        end else begin
            run0 <= run0 + 1;
        end
        prev0 <= led[0];
        if (irq === 1'b1 && prev_irq === 1'b0) irq_rise.push_back(cyc);
        prev_irq <= irq;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one APB transfer; checks the single-wait-state handshake on the way
    task automatic xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
        @(posedge clk); #1;
        bus.PADDR = addr; bus.PWRITE = wr; bus.PWDATA = wdata;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        chk("pready_access1", 32'(bus.PREADY), 32'd0);
        @(posedge clk); #1;
        chk("pready_access2", 32'(bus.PREADY), 32'd1);
        rdata = bus.PRDATA;
        err   = bus.PSLVERROR;
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        chk("pready_done", 32'(bus.PREADY), 32'd0);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        logic [31:0] r;
        logic        e;
        xfer(addr, 1'b1, data, r, e);
        chk("wr_err", 32'(e), 32'd0);
        chk("wr_prdata", r, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        xfer(addr, 1'b0, 32'd0, r, e);
        chk("rd_err", 32'(e), 32'd0);
        chk(tag, r, exp);
    endtask

    task automatic count20(output int c0, output int c1);
        c0 = 0; c1 = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            c0 += int'(led[0]);
            c1 += int'(led[1]);
        end
    endtask

    // wait for a LED0 rising edge, then clear the run queues
    task automatic sync_led_rise();
        int   ok = 0;
        logic lp = led[0];
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (led[0] && !lp) begin ok = 1; break; end
            lp = led[0];
        end
        chk("led_rise_seen", 32'(ok), 32'd1);
        @(negedge clk); #1;
        hiq.delete();
        loq.delete();
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          c0, c1, found;

        rst = 1'b1;
        bus.PADDR = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        bus.PWRITE = 1'b0; bus.PWDATA = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready",  32'(bus.PREADY),    32'd0);
        chk("rst_prdata",  bus.PRDATA,         32'd0);
        chk("rst_pslverr", 32'(bus.PSLVERROR), 32'd0);
        chk("rst_led",     32'(led),           32'd0);
        chk("rst_irq",     32'(irq),           32'd0);
        rst = 1'b0;
        rd_chk("rst_ctrl", 12'h000, 32'h0);

        // APB timing and basic readback
        wr(12'h008, 32'h9);
        rd_chk("period_rb", 12'h008, 32'h9);

        // unmapped accesses
        xfer(12'h040, 1'b1, 32'hFFFF, r, e);
        chk("unmap_wr_err", 32'(e), 32'd1);
        chk("unmap_wr_data", r, 32'd0);
        xfer(12'h040, 1'b0, 32'h0, r, e);
        chk("unmap_rd_err", 32'(e), 32'd1);
        chk("unmap_rd_data", r, 32'd0);
        xfer(12'h018, 1'b0, 32'h0, r, e);
        chk("duty2_err", 32'(e), 32'd1);
        rd_chk("period_kept", 12'h008, 32'h9);
        rd_chk("ctrl_kept", 12'h000, 32'h0);

        // duty cycle: 3/10 on ch0, duty>period on ch1
        wr(12'h004, 32'h0);
        wr(12'h010, 32'h3);
        wr(12'h014, 32'hA);
        wr(12'h000, 32'h301);
        rd_chk("duty1_rb", 12'h014, 32'hA);
        rd_chk("ctrl_rb", 12'h000, 32'h301);
        count20(c0, c1);
        chk("duty0_high", 32'(c0), 32'd6);
        chk("duty1_high", 32'(c1), 32'd20);

        // polarity inversion
        wr(12'h000, 32'h305);
        repeat (2) @(posedge clk);
        count20(c0, c1);
        chk("pol_duty0_high", 32'(c0), 32'd14);
        chk("pol_duty1_high", 32'(c1), 32'd0);
        wr(12'h000, 32'h301);

        // duty shadowing: current period keeps 3, next shows 7
        repeat (12) @(posedge clk);
        sync_led_rise();
        wr(12'h010, 32'h7);
        repeat (30) @(posedge clk);
        chk("shadow_runs", 32'(hiq.size() >= 2), 32'd1);
        chk("shadow_cur", 32'((hiq.size() > 0) ? hiq[0] : -1), 32'd3);
        chk("shadow_next", 32'((hiq.size() > 1) ? hiq[1] : -1), 32'd7);

        // period shadowing: low run 7 this period, 2 once PERIOD=4 applies
        wr(12'h010, 32'h3);
        repeat (25) @(posedge clk);
        sync_led_rise();
        wr(12'h008, 32'h4);
        repeat (30) @(posedge clk);
        chk("period_cur_low", 32'((loq.size() > 0) ? loq[0] : -1), 32'd7);
        chk("period_next_low", 32'((loq.size() > 1) ? loq[1] : -1), 32'd2);
        rd_chk("period4_rb", 12'h008, 32'h4);

        // interrupt: PRESCALE=1, PERIOD=3 -> wrap every 8 clocks
        wr(12'h000, 32'h300);
        wr(12'h00C, 32'h1);
        wr(12'h004, 32'h1);
        wr(12'h008, 32'h3);
        rd_chk("prescale_rb", 12'h004, 32'h1);
        rd_chk("status_clear", 12'h00C, 32'h0);
        irq_rise.delete();
        wr(12'h000, 32'h303);
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (irq) begin found = 1; break; end
        end
        chk("irq_seen", 32'(found), 32'd1);
        // now just after edge R; wraps land on R-1+8k
        wr(12'h00C, 32'h1);                          // commits at R+4
        rd_chk("status_after_w1c", 12'h00C, 32'h2);  // sampled at R+7
        repeat (3) @(posedge clk);
        wr(12'h00C, 32'h1);                          // commits at R+15, same edge as wrap
        rd_chk("status_set_wins", 12'h00C, 32'h3);
        chk("irq_rise_count", 32'(irq_rise.size()), 32'd2);
        chk("irq_interval",
            32'((irq_rise.size() > 1) ? irq_rise[1] - irq_rise[0] : -1), 32'd8);
        chk("irq_high", 32'(irq), 32'd1);

        // IRQ_EN masks without clearing WRAP_PEND
        wr(12'h000, 32'h301);
        @(posedge clk); #1;
        chk("irq_masked", 32'(irq), 32'd0);
        rd_chk("status_masked", 12'h00C, 32'h3);

        // disable mid-operation
        wr(12'h000, 32'h300);
        @(posedge clk); #1;
        chk("dis_cnt", 32'(dut.cnt), 32'd0);
        chk("dis_led", 32'(led), 32'd0);
        rd_chk("dis_status", 12'h00C, 32'h1);
        wr(12'h000, 32'h304);
        @(posedge clk); #1;
        chk("dis_pol_idle", 32'(led), 32'd3);

        // reset during the WAIT state
        @(posedge clk); #1;
        bus.PADDR = 12'h004; bus.PWRITE = 1'b1; bus.PWDATA = 32'h55;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstwait_pready", 32'(bus.PREADY), 32'd0);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstwait_led", 32'(led), 32'd0);
        chk("rstwait_irq", 32'(irq), 32'd0);
        chk("rstwait_prdata", bus.PRDATA, 32'd0);
        chk("rstwait_pslverr", 32'(bus.PSLVERROR), 32'd0);
        rd_chk("rstwait_prescale", 12'h004, 32'h0);
        rd_chk("rstwait_ctrl", 12'h000, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
